// File: rtl/apb_cmd_master_pkg.sv
// Shared types for the APB command master.
//   apb_state_e : APB transfer phase (encoding shared with the existing master)
//   apb_cmd_t   : one queued command {write, addr, wdata} at the default bus widths
//   wait_cnt_w  : width of a saturating counter that must reach n
package apb_cmd_master_pkg;

  localparam int unsigned ApbAddrW = 4;
  localparam int unsigned ApbDataW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b11
  } apb_state_e;

  typedef struct packed {
    logic                write;
    logic [ApbAddrW-1:0] addr;
    logic [ApbDataW-1:0] wdata;
  } apb_cmd_t;

  // A zero-width counter is illegal, so n=0 still gets one bit.
  function automatic int unsigned wait_cnt_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB bus signals of the APB command master.
//   master : view of the bridge (drives cmd_ready/rsp_*/APB requests)
//   slave  : view of the environment (command source, response sink, APB responder)
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [ADDR_W-1:0] cmd_addr_i;
  logic [DATA_W-1:0] cmd_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_write_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              psel_o;
  logic              penable_o;
  logic [ADDR_W-1:0] paddr_o;
  logic              pwrite_o;
  logic [DATA_W-1:0] pwdata_o;
  logic [DATA_W-1:0] prdata_i;
  logic              pready_i;
  logic              pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           prdata_i, pready_i, pslverr_i,
    output cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
           prdata_i, pready_i, pslverr_i,
    input  cmd_ready_o, rsp_valid_o, rsp_write_o, rsp_rdata_o, rsp_err_o,
           psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
  );
endinterface

// File: rtl/apb_cmd_master_fifo.sv
// Command FIFO of the APB command master.
//   i_push/i_data : write one command (ignored when full)
//   i_pop/o_data  : o_data is the head; i_pop drops it (ignored when empty)
//   o_full/o_empty/o_count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module apb_cmd_fifo
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     i_push,
  input  apb_cmd_t                 i_data,
  input  logic                     i_pop,
  output apb_cmd_t                 o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];

  apb_cmd_t        r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == FullCnt);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB initiator bridge: queues commands from a valid/ready port and runs them
// one at a time as IDLE/SETUP/ACCESS transfers, returning one response each.
//   pclk, preset_n : clock, asynchronous active-low reset
//   bus (master)   : cmd_* command port, rsp_* response port, APB request/response
//   busy_o         : commands queued, transfer in flight or response pending
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_W     = ApbAddrW,
  parameter int unsigned DATA_W     = ApbDataW,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                pclk,
  input  logic                preset_n,
  apb_cmd_master_if.master    bus,
  output logic                busy_o
);
  localparam int unsigned WaitW = wait_cnt_w(TIMEOUT);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  apb_state_e          r_state;
  apb_state_e          w_state_next;
  logic [WaitW-1:0]    r_wait;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_rsp_valid;
  logic                r_rsp_write;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  apb_cmd_t            w_push_cmd;
  apb_cmd_t            w_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                w_rsp_take;
  logic                w_issue;
  logic                w_done;
  logic                w_abort;

  assign w_push_cmd.write = bus.cmd_write_i;
  assign w_push_cmd.addr  = bus.cmd_addr_i;
  assign w_push_cmd.wdata = bus.cmd_wdata_i;

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pclk     (pclk),
    .preset_n (preset_n),
    .i_push   (bus.cmd_valid_i),
    .i_data   (w_push_cmd),
    .i_pop    (w_issue),
    .o_data   (w_head),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty),
    .o_count  (w_fifo_count)
  );

  assign w_rsp_take = r_rsp_valid & bus.rsp_ready_i;
  // A response leaving at this edge frees the slot, so the next transfer may
  // start at the same edge; this keeps back-to-back transfers at three cycles.
  assign w_issue = (r_state == IDLE) & ~w_fifo_empty & (~r_rsp_valid | w_rsp_take);
  assign w_done  = (r_state == ACCESS) & bus.pready_i;
  assign w_abort = (r_state == ACCESS) & ~bus.pready_i & (TIMEOUT != 0) &
                   (r_wait == WaitLast);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_issue) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      ACCESS:  if (w_done || w_abort) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // psel/penable decode straight from the state register, so reset drops
  // them without waiting for a clock edge.
  always_comb begin
    bus.psel_o    = (r_state != IDLE);
    bus.penable_o = (r_state == ACCESS);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_wait   <= '0;
    end else begin
      if (w_issue) begin
        r_paddr  <= w_head.addr;
        r_pwrite <= w_head.write;
        r_pwdata <= w_head.wdata;
        r_wait   <= '0;
      end else if ((r_state == ACCESS) && !bus.pready_i && !w_abort && (r_wait != '1)) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_done) begin
      r_rsp_valid <= 1'b1;
      r_rsp_write <= r_pwrite;
      r_rsp_rdata <= (!r_pwrite && !bus.pslverr_i) ? bus.prdata_i : '0;
      r_rsp_err   <= bus.pslverr_i;
    end else if (w_abort) begin
      r_rsp_valid <= 1'b1;
      r_rsp_write <= r_pwrite;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b1;
    end else if (w_rsp_take) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready_o = ~w_fifo_full;
  assign bus.paddr_o     = r_paddr;
  assign bus.pwrite_o    = r_pwrite;
  assign bus.pwdata_o    = r_pwdata;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_write_o = r_rsp_write;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o   = r_rsp_err;
  assign busy_o          = ~w_fifo_empty | (r_state != IDLE) | r_rsp_valid;

  // Occupancy is visible through cmd_ready_o/busy_o; the raw count is unused here.
  logic w_unused;
  assign w_unused = ^w_fifo_count;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed timing scenarios plus a
// randomized phase, all responses checked against a transaction-level model.
module tb_apb_cmd_master;
  import apb_cmd_master_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 15;
  localparam int          NO_READY = 100;  // wait count that forces a timeout

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic busy;

  always #5 pclk = ~pclk;

  apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_cmd_master #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TO)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus),
    .busy_o   (busy)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            waits;
    logic          err;
  } xfer_t;

  typedef struct {
    logic          w;
    logic [DW-1:0] rd;
    logic          err;
  } rsp_t;

  xfer_t         issue_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] slave_mem [16];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            nxt_waits = 0;
  logic          nxt_err = 1'b0;
  int            cur_waits = 0;
  logic          cur_err = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  xfer_t         mon_x;
  rsp_t          mon_r;
  logic          rand_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transaction-level model: commands execute in order; outcome follows from
  // the planned wait count and error flag for each command.
  always @(posedge pclk) begin
    if (preset_n) begin
      if (bus.cmd_valid_i && bus.cmd_ready_o) begin
        mon_x = '{w: bus.cmd_write_i, a: bus.cmd_addr_i, d: bus.cmd_wdata_i,
                  waits: nxt_waits, err: nxt_err};
        mon_r.w   = mon_x.w;
        mon_r.err = (nxt_waits >= int'(TO)) || nxt_err;
        mon_r.rd  = (!mon_x.w && !mon_r.err) ? model_mem[mon_x.a] : '0;
        if (mon_x.w && !mon_r.err) model_mem[mon_x.a] = mon_x.d;
        issue_q.push_back(mon_x);
        rsp_q.push_back(mon_r);
      end
      if (bus.psel_o && !bus.penable_o) begin
        if (issue_q.size() == 0) begin
          check_eq("setup_without_command", 32'd1, 32'd0);
        end else begin
          mon_x = issue_q.pop_front();
          check_eq("setup_paddr", bus.paddr_o, mon_x.a);
          check_eq("setup_pwrite", bus.pwrite_o, mon_x.w);
          if (mon_x.w) check_eq("setup_pwdata", bus.pwdata_o, mon_x.d);
          cur_waits = mon_x.waits;
          cur_err   = mon_x.err;
          cur_addr  = mon_x.a;
          cur_wdata = bus.pwdata_o;
        end
      end
      if (bus.psel_o && bus.penable_o) begin
        check_eq("access_paddr_stable", bus.paddr_o, cur_addr);
        check_eq("access_pwdata_stable", bus.pwdata_o, cur_wdata);
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (rsp_q.size() == 0) begin
          check_eq("response_without_command", 32'd1, 32'd0);
        end else begin
          mon_r = rsp_q.pop_front();
          check_eq("rsp_write", bus.rsp_write_o, mon_r.w);
          check_eq("rsp_err", bus.rsp_err_o, mon_r.err);
          check_eq("rsp_rdata", bus.rsp_rdata_o, mon_r.rd);
        end
      end
    end
  end

  // APB responder with its own memory; wait states and error per planned command.
  initial begin : responder
    int acc_cnt;
    acc_cnt = 0;
    bus.pready_i  = 1'b0;
    bus.pslverr_i = 1'b0;
    bus.prdata_i  = '0;
    forever begin
      @(negedge pclk);
      if (bus.psel_o && bus.penable_o) begin
        if (acc_cnt == cur_waits) begin
          bus.pready_i  = 1'b1;
          bus.pslverr_i = cur_err;
          bus.prdata_i  = bus.pwrite_o ? DW'($urandom) : slave_mem[bus.paddr_o];
          if (bus.pwrite_o && !cur_err) slave_mem[bus.paddr_o] = bus.pwdata_o;
        end else begin
          bus.pready_i  = 1'b0;
          bus.pslverr_i = 1'($urandom);
          bus.prdata_i  = DW'($urandom);
        end
        acc_cnt++;
      end else begin
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Called right after a negedge; returns at the negedge following acceptance.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic err);
    int n;
    n = 0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_write_i = w;
    bus.cmd_addr_i  = a;
    bus.cmd_wdata_i = d;
    nxt_waits = waits;
    nxt_err   = err;
    while (!bus.cmd_ready_o && n < 100) begin
      @(negedge pclk);
      n++;
    end
    @(negedge pclk);
    bus.cmd_valid_i = 1'b0;
    if (n >= 100) check_eq("send_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || rsp_q.size() != 0) && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check_eq("idle_reached", (busy || rsp_q.size() != 0) ? 32'd0 : 32'd1, 32'd1);
  endtask

  task automatic count_penable(input int window, output int cnt);
    cnt = 0;
    for (int c = 0; c < window; c++) begin
      @(negedge pclk);
      if (bus.penable_o) cnt++;
    end
  endtask

  initial begin : main
    int setups[$];
    int cnt;
    int w;
    int gap;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = '0;
      slave_mem[i] = '0;
    end
    bus.cmd_valid_i = 1'b0;
    bus.cmd_write_i = 1'b0;
    bus.cmd_addr_i  = '0;
    bus.cmd_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge pclk);
    check_eq("reset_cmd_ready", bus.cmd_ready_o, 1);
    check_eq("reset_rsp_valid", bus.rsp_valid_o, 0);
    check_eq("reset_psel", bus.psel_o, 0);
    check_eq("reset_penable", bus.penable_o, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_paddr", bus.paddr_o, 0);
    check_eq("reset_rsp_rdata", bus.rsp_rdata_o, 0);
    preset_n = 1'b1;
    @(negedge pclk);

    // Write 0x0 <- 0xFF then read it back, zero wait states
    send(1'b1, 4'h0, 8'hFF, 0, 1'b0);
    check_eq("t1_psel_after_e0", bus.psel_o, 0);
    check_eq("t1_busy_after_e0", busy, 1);
    @(negedge pclk);
    check_eq("t1_setup_psel", bus.psel_o, 1);
    check_eq("t1_setup_penable", bus.penable_o, 0);
    @(negedge pclk);
    check_eq("t1_access_penable", bus.penable_o, 1);
    @(negedge pclk);
    check_eq("t1_wr_rsp_valid", bus.rsp_valid_o, 1);
    check_eq("t1_wr_psel_low", bus.psel_o, 0);
    check_eq("t1_wr_rsp_err", bus.rsp_err_o, 0);
    bus.rsp_ready_i = 1'b1;
    @(negedge pclk);
    bus.rsp_ready_i = 1'b0;
    check_eq("t1_rsp_cleared", bus.rsp_valid_o, 0);
    send(1'b0, 4'h0, 8'h00, 0, 1'b0);
    repeat (3) @(negedge pclk);
    check_eq("t1_rd_rsp_valid", bus.rsp_valid_o, 1);
    check_eq("t1_rd_rdata", bus.rsp_rdata_o, 8'hFF);
    check_eq("t1_rd_write", bus.rsp_write_o, 0);
    check_eq("t1_rd_err", bus.rsp_err_o, 0);

    // Response held: four pushes fill the FIFO and nothing issues
    send(1'b1, 4'h3, 8'hA5, 0, 1'b0);
    send(1'b0, 4'h3, 8'h00, 0, 1'b0);
    send(1'b1, 4'h7, 8'h5A, 0, 1'b0);
    send(1'b0, 4'h7, 8'h00, 0, 1'b0);
    check_eq("t2_full_cmd_ready", bus.cmd_ready_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      check_eq("t3_no_setup_while_held", bus.psel_o, 0);
      check_eq("t3_fifo_holds_full", bus.cmd_ready_o, 0);
    end
    bus.rsp_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (bus.psel_o && !bus.penable_o) setups.push_back(c);
    end
    check_eq("t2_setup_count", setups.size(), 4);
    for (int i = 1; i < setups.size(); i++)
      check_eq("t2_setup_spacing", setups[i] - setups[i-1], 3);
    wait_idle(50);
    check_eq("t2_busy_low", busy, 0);

    // Three wait states, read completes with PSLVERR
    send(1'b0, 4'h5, 8'h00, 3, 1'b1);
    count_penable(12, cnt);
    check_eq("t4_penable_cycles", cnt, 4);
    wait_idle(20);

    // Randomized traffic with random response back-pressure
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge pclk);
          w = $urandom_range(0, 19);
          send(1'($urandom), AW'($urandom), DW'($urandom),
               (w == 0) ? NO_READY : ((w < 5) ? int'($urandom_range(1, 4)) : 0),
               ($urandom_range(0, 4) == 0));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge pclk);
          bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.rsp_ready_i = 1'b1;
    wait_idle(400);

    // Stalled responder: abort after TIMEOUT access cycles
    send(1'b0, 4'h2, 8'h00, NO_READY, 1'b0);
    count_penable(30, cnt);
    check_eq("t5_timeout_access_cycles", cnt, TO);
    wait_idle(20);

    // Reset in the middle of ACCESS with a second command queued
    send(1'b1, 4'h9, 8'h33, NO_READY, 1'b0);
    send(1'b0, 4'h9, 8'h00, 0, 1'b0);
    cnt = 0;
    while (!bus.penable_o && cnt < 10) begin
      @(negedge pclk);
      cnt++;
    end
    check_eq("t6_reached_access", bus.penable_o, 1);
    repeat (2) @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    check_eq("t6_psel_async_drop", bus.psel_o, 0);
    check_eq("t6_penable_async_drop", bus.penable_o, 0);
    check_eq("t6_cmd_ready", bus.cmd_ready_o, 1);
    check_eq("t6_fifo_empty_busy", busy, 0);
    check_eq("t6_rsp_valid", bus.rsp_valid_o, 0);
    issue_q.delete();
    rsp_q.delete();
    @(negedge pclk);
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);
    check_eq("t6_stays_idle", bus.psel_o, 0);
    check_eq("t6_stays_not_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
